// File: rtl/pc_call_stack_if.sv
// Control strobes and status bus for the program-counter stage.
// master drives strobes and target; slave returns pc and stack status.
interface pc_call_stack_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             inc;
  logic             load;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] addr_in;
  logic [WIDTH-1:0] pc;
  logic             tc;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             err;

  modport master (
    output inc, load, call, ret, addr_in,
    input  pc, tc, depth, empty, full, err
  );

  modport slave (
    input  inc, load, call, ret, addr_in,
    output pc, tc, depth, empty, full, err
  );
endinterface

// File: rtl/pc_call_stack.sv
// Program counter with load, increment and a LIFO return-address stack.
// Faulting stack commands only raise the sticky err flag.
module pc_call_stack #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  pc_call_stack_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [WIDTH-1:0] top;
  logic             empty, full;
  logic             a_bad, a_ret, a_call;
  logic             a_load, a_inc;

  // One-hot action select, fixed priority.
  always_comb begin
    a_bad  = bus.call & bus.ret;
    a_ret  = bus.ret & ~bus.call;
    a_call = bus.call & ~bus.ret;
    a_load = bus.load & ~bus.call & ~bus.ret;
    a_inc  = bus.inc & ~bus.load
           & ~bus.call & ~bus.ret;
    empty  = (depth_q == '0);
    full   = (depth_q == DW'(DEPTH));
    top    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i) == depth_q - DW'(1))
        top = stk_q[i];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    depth_d = depth_q;
    err_d   = err_q;
    stk_d   = stk_q;
    unique case (1'b1)
      a_bad: err_d = 1'b1;
      a_ret: begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          pc_d    = top;
          depth_d = depth_q - DW'(1);
        end
      end
      a_call: begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            if (DW'(i) == depth_q)
              stk_d[i] = pc_q + WIDTH'(1);
          end
          depth_d = depth_q + DW'(1);
          pc_d    = bus.addr_in;
        end
      end
      a_load: pc_d = bus.addr_in;
      a_inc:  pc_d = pc_q + WIDTH'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Entries at or above depth are don't-care, so no reset needed.
  always_ff @(posedge clk) begin
    stk_q <= stk_d;
  end

  assign bus.pc    = pc_q;
  assign bus.tc    = ~rst & a_inc & (&pc_q);
  assign bus.depth = depth_q;
  assign bus.empty = empty;
  assign bus.full  = full;
  assign bus.err   = err_q;
endmodule
